// File: rtl/max_pool_stream_pkg.sv
// -----------------------------------------------------------------------------
// max_pool_stream_pkg
// Shared definitions for the streaming max-pool block:
//   - pool_state_e    : FSM state encoding (ACCUM collecting, HOLD presenting)
//   - idx_width()     : width of a per-lane beat index, minimum 1 bit
//   - size_width()    : width of the pool-size configuration field
//   - clamp_pool_size : maps a raw window length onto the legal range 1..MAX_POOL
// -----------------------------------------------------------------------------
package max_pool_stream_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } pool_state_e;

  // Index of a beat inside a window of up to max_pool beats.
  function automatic int idx_width(input int max_pool);
    if (max_pool > 1) begin
      return $clog2(max_pool);
    end else begin
      return 1;
    end
  endfunction

  // Field wide enough to carry the value max_pool itself.
  function automatic int size_width(input int max_pool);
    if (max_pool > 1) begin
      return $clog2(max_pool + 1);
    end else begin
      return 1;
    end
  endfunction

  // A zero-length window makes no sense, so it behaves as a one-beat window;
  // anything longer than the hardware supports saturates at max_pool.
  function automatic int clamp_pool_size(input int size, input int max_pool);
    if (size < 1) begin
      return 1;
    end else if (size > max_pool) begin
      return max_pool;
    end else begin
      return size;
    end
  endfunction

endpackage

// File: rtl/max_pool_stream_if.sv
// -----------------------------------------------------------------------------
// max_pool_stream_if
// Input and output valid/ready streams of the max-pool block.
//   IN_VALID / IN_READY / IN_DATA    : beats into the pool, NUM_CH lanes packed,
//                                      lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   OUT_VALID / OUT_READY / OUT_DATA : pooled results, same lane packing
//   OUT_IDX                          : per-lane beat index of the maximum,
//                                      lane k at [k*IDX_W +: IDX_W]
// Modports:
//   master : the stream producer/consumer around the block
//   slave  : the max-pool block itself
// -----------------------------------------------------------------------------
interface max_pool_stream_if
  import max_pool_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int MAX_POOL   = 8
);

  localparam int IDX_W = idx_width(MAX_POOL);

  logic                         IN_VALID;
  logic                         IN_READY;
  logic [NUM_CH*DATA_WIDTH-1:0] IN_DATA;
  logic                         OUT_VALID;
  logic                         OUT_READY;
  logic [NUM_CH*DATA_WIDTH-1:0] OUT_DATA;
  logic [NUM_CH*IDX_W-1:0]      OUT_IDX;

  modport master (
    output IN_VALID, IN_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_IDX
  );

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_IDX
  );

endinterface

// File: rtl/max_pool_stream_lane.sv
// -----------------------------------------------------------------------------
// max_compare_lane
// One pooling lane: running maximum plus the beat index where it was found.
//   clk, rst_n : clock, synchronous active-low reset
//   load_en    : a beat is being accepted this cycle
//   first      : the accepted beat is beat 0 of a window (loads unconditionally)
//   is_signed  : compare as two's complement (1) or unsigned (0)
//   beat_idx   : index of the accepted beat within its window
//   din        : this lane's element of the accepted beat
//   acc_data   : registered running maximum
//   acc_idx    : registered index of the running maximum
// -----------------------------------------------------------------------------
module max_compare_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  first,
  input  logic                  is_signed,
  input  logic [IDX_W-1:0]      beat_idx,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] acc_data,
  output logic [IDX_W-1:0]      acc_idx
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  greater_s;

  // Strict greater-than compare; equality keeps the earlier maximum.
  always_comb begin
    if (is_signed) begin
      greater_s = ($signed(din) > $signed(acc_q));
    end else begin
      greater_s = (din > acc_q);
    end
  end

  // Beat 0 seeds the lane; later beats replace it only when strictly larger.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (load_en && (first || greater_s)) begin
      acc_d = din;
      if (first) begin
        idx_d = '0;
      end else begin
        idx_d = beat_idx;
      end
    end else begin
      acc_d = acc_q;
      idx_d = idx_q;
    end
  end

  // Accumulator and index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

  assign acc_data = acc_q;
  assign acc_idx  = idx_q;

endmodule

// File: rtl/max_pool_stream.sv
// -----------------------------------------------------------------------------
// max_pool_stream
// Streaming max-pool over windows of CFG_POOL_SIZE beats on NUM_CH lanes.
//   CLK           : clock, rising edge
//   RESET         : synchronous active-low reset
//   CFG_POOL_SIZE : window length in beats, sampled with beat 0 of each window
//                   (0 acts as 1, values above MAX_POOL act as MAX_POOL)
//   CFG_SIGNED    : 1 = two's-complement compare, 0 = unsigned, sampled with beat 0
//   bus           : input and output streams (slave side)
// The result of a window is presented one cycle after its final beat and held
// until taken. While a result is held, a new beat is only accepted in the same
// cycle the result is taken, so windows can run back to back.
// -----------------------------------------------------------------------------
module max_pool_stream
  import max_pool_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_CH     = 4,
  parameter  int MAX_POOL   = 8,
  localparam int IDX_W      = idx_width(MAX_POOL),
  localparam int SIZE_W     = size_width(MAX_POOL)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [SIZE_W-1:0]   CFG_POOL_SIZE,
  input  logic                CFG_SIGNED,
  max_pool_stream_if.slave    bus
);

  pool_state_e       state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              signed_q, signed_d;

  logic              in_ready_s;
  logic              accept_s;
  logic              first_s;
  logic              last_s;
  logic [SIZE_W-1:0] cfg_size_s;
  logic [SIZE_W-1:0] eff_size_s;

  logic [DATA_WIDTH-1:0]        lane_data_s [NUM_CH];
  logic [IDX_W-1:0]             lane_idx_s  [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0] out_data_s;
  logic [NUM_CH*IDX_W-1:0]      out_idx_s;

  // In HOLD a beat may only enter together with the result leaving.
  always_comb begin
    if (state_q == ST_ACCUM) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = bus.OUT_READY;
    end
  end

  assign accept_s = bus.IN_VALID & in_ready_s;

  // The counter sits at 0 exactly when the next accepted beat opens a window,
  // so beat 0 must use the live configuration rather than the latched one.
  always_comb begin
    cfg_size_s = SIZE_W'(clamp_pool_size(int'(CFG_POOL_SIZE), MAX_POOL));
    first_s    = (cnt_q == '0);
    if (first_s) begin
      eff_size_s = cfg_size_s;
    end else begin
      eff_size_s = size_q;
    end
    last_s = (int'(cnt_q) == (int'(eff_size_s) - 1));
  end

  // Beat counter and configuration latched with beat 0.
  always_comb begin
    cnt_d    = cnt_q;
    size_d   = size_q;
    signed_d = signed_q;
    if (accept_s) begin
      if (last_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
      if (first_s) begin
        size_d   = cfg_size_s;
        signed_d = CFG_SIGNED;
      end else begin
        size_d   = size_q;
        signed_d = signed_q;
      end
    end else begin
      cnt_d    = cnt_q;
      size_d   = size_q;
      signed_d = signed_q;
    end
  end

  // Next-state logic: close a window on its last beat, release HOLD on OUT_READY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept_s && last_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (bus.OUT_READY) begin
          // A one-beat window accepted while draining produces the next result immediately.
          if (accept_s && last_s) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State, counter and latched configuration registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= ST_ACCUM;
      cnt_q    <= '0;
      size_q   <= SIZE_W'(1);
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      signed_q <= signed_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    max_compare_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
    ) u_lane (
      .clk       (CLK),
      .rst_n     (RESET),
      .load_en   (accept_s),
      .first     (first_s),
      .is_signed (signed_q),
      .beat_idx  (cnt_q),
      .din       (bus.IN_DATA[k*DATA_WIDTH +: DATA_WIDTH]),
      .acc_data  (lane_data_s[k]),
      .acc_idx   (lane_idx_s[k])
    );
  end

  // Pack the lane registers onto the output bus. The lane accumulators only
  // move when a beat is accepted, which in HOLD coincides with the result being
  // taken, so the presented result stays stable while stalled.
  always_comb begin
    out_data_s = '0;
    out_idx_s  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      out_data_s[k*DATA_WIDTH +: DATA_WIDTH] = lane_data_s[k];
      out_idx_s[k*IDX_W +: IDX_W]            = lane_idx_s[k];
    end
  end

  assign bus.IN_READY  = in_ready_s;
  assign bus.OUT_VALID = (state_q == ST_HOLD);
  assign bus.OUT_DATA  = out_data_s;
  assign bus.OUT_IDX   = out_idx_s;

endmodule
